// File: rtl/swap_arbiter_2ch.sv
// -----------------------------------------------------------------------------
// swap_arbiter_2ch
//
// Two requesters share one registered 16-bit byte-swap stage. Each request
// selects byte-swap ({d[7:0], d[15:8]}) or pass-through. A round-robin
// arbiter picks one requester per cycle. The result is held in a single
// output register and presented on a valid/ready interface, tagged with the
// channel that produced it. Each channel has a free-running counter of
// accepted requests for debug and status.
//
// Parameters
//   CNT_W        width of the per-channel accept counters (wrap on overflow)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active-low
//   en           1: new grants allowed; 0: no new grants, output still drains
//   req0_valid   channel 0 request valid
//   req0_data    channel 0 operand
//   req0_swap    channel 0: 1 = byte-swap, 0 = pass-through
//   req0_ready   channel 0 accepted this cycle (combinational)
//   req1_valid   channel 1 request valid
//   req1_data    channel 1 operand
//   req1_swap    channel 1: 1 = byte-swap, 0 = pass-through
//   req1_ready   channel 1 accepted this cycle (combinational)
//   out_valid    output register holds a result
//   out_data     result
//   out_src      channel that produced out_data
//   out_ready    consumer accepts out_data this cycle
//   cnt0         number of channel-0 requests accepted
//   cnt1         number of channel-1 requests accepted
// -----------------------------------------------------------------------------
module swap_arbiter_2ch #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req0_valid,
  input  logic [15:0]      req0_data,
  input  logic             req0_swap,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_data,
  input  logic             req1_swap,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  logic        last_grant;

  logic        grant;
  logic        load;
  logic [15:0] sel_data;
  logic        sel_swap;
  logic [15:0] next_data;

  // ---------------------------------------------------------------------------
  // Arbitration and load decision.
  // The output register can take a new result when it is empty, or when the
  // consumer is taking the current one in this same cycle. Gating with rst_n
  // keeps both readies low while reset is asserted so no requester believes
  // it handshook on a cycle whose state update is thrown away.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    if (req0_valid && req1_valid) begin
      // Contention: whoever did not win last time goes now.
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end

    load = rst_n && en && (req0_valid || req1_valid) &&
           ((state == EMPTY) || out_ready);

    req0_ready = load && (grant == 1'b0);
    req1_ready = load && (grant == 1'b1);
  end

  // Datapath: mux the winning operand, then optionally swap bytes.
  assign sel_data  = grant ? req1_data : req0_data;
  assign sel_swap  = grant ? req1_swap : req0_swap;
  assign next_data = sel_swap ? {sel_data[7:0], sel_data[15:8]} : sel_data;

  // out_valid is a direct decode of the registered state, so it is glitch-free.
  assign out_valid = (state == FULL);

  // ---------------------------------------------------------------------------
  // State, output register, round-robin pointer and counters.
  // A load in FULL with out_ready high replaces the old result on the same
  // edge the consumer takes it, which sustains one result per cycle.
  // A drain without a load only clears the state; out_data and out_src keep
  // their last values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
      cnt0       <= '0;
      cnt1       <= '0;
    end else if (load) begin
      state      <= FULL;
      out_data   <= next_data;
      out_src    <= grant;
      last_grant <= grant;
      if (grant) cnt1 <= cnt1 + CNT_W'(1);
      else       cnt0 <= cnt0 + CNT_W'(1);
    end else if ((state == FULL) && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule
